// File: rtl/mem_responder.sv
// Word-organised data memory for the core mem port: registered write-first read, zero-fill on reset.
// Optional write protection of the low ro_words_p words is enabled by defining MEM_RESPONDER_WRPROT_EN.
module mem_responder #(
    parameter int                   wd_regs_p   = 32,
    parameter int                   depth_p     = 1024,
    parameter logic [wd_regs_p-1:0] base_addr_p = 32'h0000_0000,
    parameter int                   ro_words_p  = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [wd_regs_p-1:0] i_mem_rd_addr,
    output logic [wd_regs_p-1:0] o_mem_rd_data,
    input  logic                 i_mem_wr_en,
    input  logic [wd_regs_p-1:0] i_mem_wr_addr,
    input  logic [wd_regs_p-1:0] i_mem_wr_data,
    output logic                 o_busy,
    output logic                 o_rd_err,
    output logic                 o_wr_err
);

    localparam int                   aw_lp   = $clog2(depth_p);
    localparam logic [wd_regs_p-1:0] span_lp = wd_regs_p'(depth_p * 4);
    localparam logic [aw_lp:0]       ro_lp   = (aw_lp + 1)'(ro_words_p);
    localparam logic [aw_lp-1:0]     last_lp = aw_lp'(depth_p - 1);
`ifdef MEM_RESPONDER_WRPROT_EN
    localparam logic                 wrprot_lp = 1'b1;
`else
    localparam logic                 wrprot_lp = 1'b0;
`endif

    typedef enum logic [0:0] {ST_INIT = 1'b0, ST_READY = 1'b1} state_t;

    typedef struct packed {
        logic             ok;
        logic [aw_lp-1:0] idx;
    } dec_t;

    // Offset wraps modulo 2^wd_regs_p, so addresses below the base land far out of range.
    function automatic dec_t decode(input logic [wd_regs_p-1:0] addr);
        logic [wd_regs_p-1:0] off;
        dec_t                 r;
        off   = addr - base_addr_p;
        r.ok  = (off[1:0] == 2'b00) && (off < span_lp);
        r.idx = off[aw_lp+1:2];
        return r;
    endfunction

    state_t                 state_q, state_d;
    logic [aw_lp-1:0]       cnt_q, cnt_d;
    logic                   rd_ok_q, rd_ok_d;
    logic                   rd_err_q, rd_err_d;
    logic                   wr_err_q, wr_err_d;
    logic                   byp_q, byp_d;
    logic [wd_regs_p-1:0]   byp_data_q;
    logic [wd_regs_p-1:0]   ram_rd_q;
    logic [wd_regs_p-1:0]   mem_q [depth_p];

    dec_t                   rd_dec_s, wr_dec_s;
    logic                   wr_prot_s;
    logic                   ram_we_s;
    logic [aw_lp-1:0]       ram_waddr_s;
    logic [wd_regs_p-1:0]   ram_wdata_s;

    assign rd_dec_s  = decode(i_mem_rd_addr);
    assign wr_dec_s  = decode(i_mem_wr_addr);
    assign wr_prot_s = wrprot_lp && ({1'b0, wr_dec_s.idx} < ro_lp);

    // Next-state, RAM write-port mux and response flags.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ram_we_s    = 1'b0;
        ram_waddr_s = wr_dec_s.idx;
        ram_wdata_s = i_mem_wr_data;
        rd_ok_d     = 1'b0;
        rd_err_d    = 1'b0;
        wr_err_d    = 1'b0;
        byp_d       = 1'b0;
        case (state_q)
            ST_INIT: begin
                ram_we_s    = 1'b1;
                ram_waddr_s = cnt_q;
                ram_wdata_s = '0;
                cnt_d       = cnt_q + aw_lp'(1);
                if (cnt_q == last_lp) begin
                    state_d = ST_READY;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_READY: begin
                ram_we_s = i_mem_wr_en && wr_dec_s.ok && !wr_prot_s;
                wr_err_d = i_mem_wr_en && (!wr_dec_s.ok || wr_prot_s);
                rd_ok_d  = rd_dec_s.ok;
                rd_err_d = !rd_dec_s.ok;
                byp_d    = ram_we_s && (ram_waddr_s == rd_dec_s.idx);
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Control state and response flags with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_INIT;
            cnt_q    <= '0;
            rd_ok_q  <= 1'b0;
            rd_err_q <= 1'b0;
            wr_err_q <= 1'b0;
            byp_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_ok_q  <= rd_ok_d;
            rd_err_q <= rd_err_d;
            wr_err_q <= wr_err_d;
            byp_q    <= byp_d;
        end
    end

    // Simple dual-port storage with registered read; bypass data captured alongside.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            mem_q[ram_waddr_s] <= ram_wdata_s;
        end
        ram_rd_q   <= mem_q[rd_dec_s.idx];
        byp_data_q <= i_mem_wr_data;
    end

    assign o_mem_rd_data = rd_ok_q ? (byp_q ? byp_data_q : ram_rd_q) : '0;
    assign o_rd_err      = rd_err_q;
    assign o_wr_err      = wr_err_q;
    assign o_busy        = (state_q == ST_INIT);

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Word-organised data memory that answers the core's memory-access port: combinational read address in, registered read data out, single-cycle write strobe.
- Sits beside the core top level and connects directly to its mem interface (rd_addr/rd_data/wr_en/wr_addr/wr_data).
- Holds its own storage array.
- Zero-fills the array after reset with an init sequencer, and flags misaligned and out-of-range accesses.

Parameters:
- wd_regs_p, 32, data and address width in bits.
- depth_p, 1024, number of words; power of two, >= 4.
- base_addr_p, 32'h0000_0000, byte address of word 0; aligned to depth_p*4.
- ro_words_p, 256, number of words from word 0 that are write-protected (used only with MEM_RESPONDER_WRPROT_EN).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- i_mem_rd_addr  in  wd_regs_p  byte read address; sampled every cycle.
- o_mem_rd_data  out  wd_regs_p  read data, registered.
- i_mem_wr_en  in  1  write strobe.
- i_mem_wr_addr  in  wd_regs_p  byte write address.
- i_mem_wr_data  in  wd_regs_p  write data.
- o_busy  out  1  high while the init sequencer runs.
- o_rd_err  out  1  registered; aligned with o_mem_rd_data.
- o_wr_err  out  1  registered one-cycle pulse, one cycle after the offending write.

Behaviour:
Reset values (rst_n=0 at a rising edge):
- o_mem_rd_data=0, o_rd_err=0, o_wr_err=0, o_busy=1.
- FSM=INIT, init counter=0.

Address decode (same rule for read and write):
- off = addr - base_addr_p (wd_regs_p-bit, wrapping).
- Valid iff off[1:0]==0 and off < depth_p*4.
- Word index = off[$clog2(depth_p)+1:2].

FSM:
- INIT:
  - Each cycle writes 0 to word[cnt], then cnt += 1.
  - When cnt==depth_p-1 is written, go to READY next cycle. INIT lasts exactly depth_p cycles after reset release.
  - o_busy=1. External writes are dropped with no error. o_mem_rd_data=0 and o_rd_err=0.
- READY:
  - o_busy=0. Stays in READY until reset.
- Reset asserted in any state returns to INIT with cnt=0. An interrupted zero-fill restarts from word 0.

Read path (READY):
- Address sampled at edge N; data and error valid after edge N+1. Latency is 1 cycle; a new read is accepted every cycle.
- Invalid address: o_mem_rd_data=0, o_rd_err=1 for that cycle.
- A write and a read to the same word in the same cycle: the read returns the new write data (write-first).

Write path (READY):
- i_mem_wr_en=1 with a valid address: word updates at that edge.
- Invalid address: no array change, o_wr_err=1 the following cycle.
- i_mem_wr_en=0: i_mem_wr_addr and i_mem_wr_data are ignored and o_wr_err=0.

Other rules:
- No byte enables; full-word accesses only.
- At most one write and one read per cycle. Storage must be inferable as simple dual-port RAM with a registered read, plus a bypass mux for write-first.
- Address arithmetic wraps modulo 2^wd_regs_p. An address below base_addr_p wraps to a large offset and is flagged invalid.

Optional Feature:
MEM_RESPONDER_WRPROT_EN
- Defined:
  - Words 0..ro_words_p-1 are read-only. A READY-state write to them is dropped and raises o_wr_err next cycle.
  - Reads to these words are unaffected.
  - INIT still zero-fills them.
- Undefined:
  - All valid words are writable and ro_words_p is ignored.

Test Plan:
- Reset held 3 cycles, then released → o_busy=1 for exactly 1024 cycles, then 0; reading word 0x3FC immediately after returns 0.
- READY: write 0xDEADBEEF to 0x0000_0400, then read 0x400 next cycle → o_mem_rd_data=0xDEADBEEF one cycle later, o_rd_err=0.
- Same-cycle write 0x12345678 to 0x10 with read 0x10 → next cycle o_mem_rd_data=0x12345678; a read of 0x10 on the following cycle also returns 0x12345678.
- Read 0x0000_0002 (misaligned) and read 0x0000_1000 (out of range) on consecutive cycles → o_rd_err=1, data=0 on both response cycles. A write to 0x1000 → o_wr_err pulses once and the array is unchanged.
- Drop rst_n at cycle 500 of INIT for one cycle → INIT restarts, o_busy stays high 1024 more cycles; a write of 0x5 to 0x20 during INIT is dropped and reads back 0 after READY.
- With MEM_RESPONDER_WRPROT_EN: write 0xAA to 0x3FC (word 255) → o_wr_err=1, reads back 0. Write 0xBB to 0x400 (word 256) → succeeds and reads back 0xBB.
